const_div_seq: RTL

Parametrised sequential divider by a compile-time constant D, producing quotient and remainder of a W-bit unsigned operand. It is the successor to the fixed 16-bit, divide-by-23 combinational residue unit: width, divisor and digit size are generic, the quotient is produced alongside the remainder, and the operand is processed K bits per clock behind a valid/ready handshake. It sits between an operand producer and any consumer of residues or quotients, such as RNS conversion or address folding.

---
 rtl/const_div_pkg.sv | 43 ++++
 rtl/const_div_step.sv | 76 +++++++
 rtl/const_div_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/const_div_pkg.sv
// Shared types and elaboration-time helpers for the sequential
// constant divider: width arithmetic, step count and FSM states.
package const_div_pkg;

    // Controller states of const_div_seq.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Largest D*2^K for which the single-digit step is a lookup table.
    localparam int ROM_MAX_ENTRIES = 4096;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        longint pow;
        res = 0;
        pow = 64'd1;
        while (pow < longint'(value)) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

    // Number of K-bit digit steps needed to consume a W-bit operand.
    function automatic int steps(input int w, input int k);
        return (w + k - 1) / k;
    endfunction

    // Remainder width: enough bits to hold any value below D.
    function automatic int rem_width(input int d);
        return (clog2(d) < 1) ? 1 : clog2(d);
    endfunction

    // Step counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/const_div_step.sv
// One radix-2^K long-division digit step by the constant D:
//   t = r*2^K + d, r_next = t mod D, q_digit = floor(t / D).
// Because r < D, t < D*2^K and the quotient digit always fits in K bits.
// Small tables are built at elaboration time; larger ones fall back to a
// restoring compare/subtract chain of K stages.
module const_div_step
    import const_div_pkg::*;
#(
    parameter  int D  = 23,
    parameter  int K  = 4,
    localparam int RW = rem_width(D)
) (
    input  logic [RW-1:0] r_i,
    input  logic [K-1:0]  d_i,
    output logic [RW-1:0] r_next_o,
    output logic [K-1:0]  q_digit_o
);

    localparam int TW      = RW + K;
    localparam int ENTRIES = D * (1 << K);
    localparam bit USE_ROM = (ENTRIES <= ROM_MAX_ENTRIES);

    // Partial dividend; numerically r*2^K + d, which is also the table index.
    logic [TW-1:0] t_s;
    assign t_s = {r_i, d_i};

    // Table entry for partial dividend idx, packed as {digit, remainder}.
    function automatic logic [TW-1:0] rom_entry(input int idx);
        return {K'(idx / D), RW'(idx % D)};
    endfunction

    if (USE_ROM) begin : g_rom
        logic [TW-1:0] rom_s [ENTRIES];
        logic [TW-1:0] entry_s;

        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            assign rom_s[i] = rom_entry(i);
        end

        // Table lookup; an index beyond the table cannot occur while r < D.
        always_comb begin
            entry_s = {TW{1'b0}};
            if (int'(t_s) < ENTRIES) begin
                entry_s = rom_s[t_s];
            end else begin
                entry_s = {TW{1'b0}};
            end
        end

        assign q_digit_o = entry_s[TW-1:RW];
        assign r_next_o  = entry_s[RW-1:0];
    end else begin : g_chain
        localparam logic [TW-1:0] D_T = TW'(D);

        logic [TW-1:0] rem_v;
        logic [K-1:0]  q_v;

        // Restoring division: try D*2^j from the top digit bit downwards.
        always_comb begin
            rem_v = t_s;
            q_v   = {K{1'b0}};
            for (int j = K - 1; j >= 0; j--) begin
                if (rem_v >= (D_T << j)) begin
                    rem_v  = rem_v - (D_T << j);
                    q_v[j] = 1'b1;
                end else begin
                    q_v[j] = 1'b0;
                end
            end
        end

        assign q_digit_o = q_v;
        assign r_next_o  = rem_v[RW-1:0];
    end

endmodule

// File: rtl/const_div_seq.sv
// Sequential unsigned divider by a compile-time constant D. The operand
// is consumed K bits per clock, MSB digit first, behind valid/ready
// handshakes on both sides. A single shift register carries the operand
// digits out of its top while the quotient digits enter at its bottom, so
// after N steps it holds the complete quotient.
module const_div_seq
    import const_div_pkg::*;
#(
    parameter  int W  = 16,
    parameter  int D  = 23,
    parameter  int K  = 4,
    localparam int RW = rem_width(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_q,
    output logic [RW-1:0] out_r,
    output logic          busy
);

    localparam int N  = steps(W, K);
    localparam int NK = N * K;
    localparam int CW = cnt_width(N);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e         state_q;
    logic [NK-1:0]  x_q;        // operand digits above, quotient digits below
    logic [RW-1:0]  r_q;        // running remainder, always < D
    logic [CW-1:0]  cnt_q;      // index of the digit step in progress
    logic [W-1:0]   out_q_q;
    logic [RW-1:0]  out_r_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [K-1:0]   digit_s;
    logic [K-1:0]   q_digit_s;
    logic [RW-1:0]  r_step_d;
    logic [NK-1:0]  x_step_d;
    logic [NK-1:0]  x_load_d;
    logic           last_s;
    logic           in_ready_s;

    // Operand zero-extended at the MSB end to a whole number of digits.
    assign x_load_d = NK'(in_x);

    assign digit_s = x_q[NK-1 -: K];
    assign last_s  = (cnt_q == CNT_LAST);

    const_div_step #(
        .D (D),
        .K (K)
    ) u_step (
        .r_i       (r_q),
        .d_i       (digit_s),
        .r_next_o  (r_step_d),
        .q_digit_o (q_digit_s)
    );

    // Shift out the consumed digit and append the new quotient digit.
    if (N > 1) begin : g_shift
        assign x_step_d = {x_q[NK-K-1:0], q_digit_s};
    end else begin : g_single
        assign x_step_d = q_digit_s;
    end

    // Ready while idle, or while a finished result is being popped so
    // that the next operand can be taken on the same edge.
    assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    // Controller, digit datapath and output registers advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= {NK{1'b0}};
            r_q         <= {RW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            out_q_q     <= {W{1'b0}};
            out_r_q     <= {RW{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= BUSY;
                        x_q     <= x_load_d;
                        r_q     <= {RW{1'b0}};
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    x_q   <= x_step_d;
                    r_q   <= r_step_d;
                    cnt_q <= cnt_q + CW'(1'b1);
                    if (last_s) begin
                        // Results are captured only here, so they stay
                        // glitch-free and stable until popped.
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_q_q     <= x_step_d[W-1:0];
                        out_r_q     <= r_step_d;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            state_q <= BUSY;
                            x_q     <= x_load_d;
                            r_q     <= {RW{1'b0}};
                            cnt_q   <= {CW{1'b0}};
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;

endmodule
